chain_path_monitor: RTL and testbench
=====================================

# chain_path_monitor

Synthesisable, parametrised monitor for configuration- and scan-chain paths. It compares up to NUM_TAPS chain tap points against a delayed copy of the chain head stream. Each tap has its own run-time latency and check mode. The block records sticky per-tap failures, a saturating error count and the first failing tap and cycle. It sits beside the fabric under test on the prog_clk domain, for use in simulation or on emulation hardware where assertions are unavailable.

## Interface
Parameters:
- NUM_TAPS, 4, number of monitored tap points (1..16)
- LAT_W, 14, latency width; history depth is 2^LAT_W − 1 bits, so the maximum latency is 2^LAT_W − 1
- ERR_W, 16, width of the error counter
- CYC_W, 32, width of the cycle counter

Ports:
- prog_clk  in  1  sole clock; all state updates on its rising edge
- pReset_n  in  1  asynchronous, active-low reset
- arm  in  1  single-cycle pulse; starts or restarts a check run
- disarm  in  1  ends the run and holds the results
- stop_on_err  in  1  when 1, the first mismatch halts the run
- head  in  1  chain head bit
- tap  in  NUM_TAPS  observed chain bits
- tap_lat  in  NUM_TAPS*LAT_W  per-tap latency; tap i uses bits [i*LAT_W +: LAT_W]
- tap_mode  in  NUM_TAPS  0 = equality check, 1 = implication-high check (only checked when the delayed head is 1)
- tap_en  in  NUM_TAPS  per-tap check enable
- checking  out  1  1 while in CHECK
- halted  out  1  1 while in HALT
- tap_err  out  NUM_TAPS  sticky per-tap mismatch flags
- err_cnt  out  ERR_W  total mismatches, saturating
- first_err_valid  out  1  set when the first mismatch is captured
- first_err_tap  out  $clog2(NUM_TAPS) (min 1)  index of the first failing tap
- first_err_cycle  out  CYC_W  value of cycle_cnt at the first mismatch
- cycle_cnt  out  CYC_W  cycles elapsed in the current run

## Operation
- States: IDLE (reset state), CHECK, HALT.
- arm from any state:
  - next state is CHECK;
  - cycle_cnt, tap_err, err_cnt, first_err_* are cleared;
  - tap_lat, tap_mode and tap_en are latched into internal registers;
  - run-time changes to these inputs are ignored until the next arm.
- arm has priority over disarm and over the transition to HALT in the same cycle.
- disarm in CHECK or HALT, with arm low: go to IDLE; all results are held.
- Every cycle in CHECK:
  - head is shifted into the history register;
  - for each latched, enabled tap i with cycle_cnt ≥ lat_i, the expected value is head as sampled lat_i cycles earlier;
  - lat_i = 0 compares against the current head combinationally;
  - mode 0: a mismatch is expected ≠ tap[i];
  - mode 1: a mismatch is expected = 1 and tap[i] = 0.
- Taps with cycle_cnt < lat_i are in warm-up: their tap value is ignored and no error is raised.
- For each mismatch in a cycle:
  - tap_err[i] is set;
  - err_cnt increases by the number of mismatching taps in that cycle, saturating at all-ones.
- If first_err_valid is 0, the first mismatch captures:
  - first_err_tap = lowest mismatching index;
  - first_err_cycle = cycle_cnt;
  - first_err_valid is set.
- With stop_on_err = 1 and any mismatch: go to HALT. In HALT, history, counters and results are frozen.
- cycle_cnt increments each CHECK cycle and saturates at all-ones. Once saturated, warm-up comparisons still hold, because cycle_cnt ≥ lat is then always true.
- In IDLE and HALT, history is not shifted and no comparisons are made.

## Timing
- pReset_n low, at any time including mid-run:
  - all outputs 0 immediately (asynchronously);
  - state IDLE;
  - history cleared.
- arm sampled at edge t: checking = 1 from t+1, and the cycle at t+1 has cycle_cnt = 0.
- A mismatch present in the CHECK cycle with cycle_cnt = k is visible at the next edge:
  - tap_err, err_cnt, first_err_* and halted all update together;
  - first_err_cycle = k.
- All outputs are registered; there are no combinational paths from input to output.
- History depth: the tap at latency L compares head from L prog_clk edges earlier. L = 2^LAT_W − 1 is legal.

## Test plan
- Reset and basic match:
  - NUM_TAPS = 4, tap0 lat = 0 with tap0 = head, random head for 100 cycles → err_cnt = 0, tap_err = 0;
  - force tap0 ≠ head at cycle_cnt = 10 → tap_err = 4'b0001, err_cnt = 1, first_err_tap = 0, first_err_cycle = 10.
- Long latency with warm-up:
  - tap1 lat = 220, driven by a 220-stage delay of head, garbage on tap1 during cycles 0..219, run 2000 cycles → err_cnt = 0;
  - repeat with lat = 16383, LAT_W = 14 → err_cnt = 0.
- Implication mode:
  - tap2 mode = 1, lat = 1, head = 0 with tap2 = 1 → no error;
  - head = 1 at cycle 5 with tap2 = 0 at cycle 6 → tap_err[2] = 1, first_err_cycle = 6.
- Simultaneous errors and saturation:
  - taps 1 and 3 mismatch in the same cycle → err_cnt += 2, first_err_tap = 1;
  - ERR_W = 4 with 20 mismatches → err_cnt = 15, held.
- stop_on_err and rearm:
  - stop_on_err = 1, first mismatch at cycle 7 → halted = 1 and checking = 0 at the next edge, cycle_cnt frozen at 7;
  - arm → all results cleared, checking = 1.
- Reset mid-run:
  - pReset_n pulsed low for half a cycle during CHECK with err_cnt = 3 → all outputs 0 immediately, state IDLE, no checking until the next arm.

Source files
------------

// File: rtl/chain_path_monitor.sv
// rtl/chain_path_monitor.sv - compares chain tap points against a delayed copy of the chain head
module chain_path_monitor #(
  parameter int NUM_TAPS = 4,
  parameter int LAT_W    = 14,
  parameter int ERR_W    = 16,
  parameter int CYC_W    = 32,
  localparam int TAP_W   = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1
) (
  input  logic                      prog_clk,
  input  logic                      pReset_n,
  input  logic                      arm,
  input  logic                      disarm,
  input  logic                      stop_on_err,
  input  logic                      head,
  input  logic [NUM_TAPS-1:0]       tap,
  input  logic [NUM_TAPS*LAT_W-1:0] tap_lat,
  input  logic [NUM_TAPS-1:0]       tap_mode,
  input  logic [NUM_TAPS-1:0]       tap_en,
  output logic                      checking,
  output logic                      halted,
  output logic [NUM_TAPS-1:0]       tap_err,
  output logic [ERR_W-1:0]          err_cnt,
  output logic                      first_err_valid,
  output logic [TAP_W-1:0]          first_err_tap,
  output logic [CYC_W-1:0]          first_err_cycle,
  output logic [CYC_W-1:0]          cycle_cnt
);
  localparam int DEPTH = (2 ** LAT_W) - 1;
  localparam int CNT_W = $clog2(NUM_TAPS + 1);
  localparam int CMP_W = (CYC_W > LAT_W) ? CYC_W : LAT_W;
  localparam int SUM_W = ERR_W + CNT_W;

  typedef enum logic [1:0] {IDLE, CHECK, HALT} state_t;
  state_t state, state_next;

  logic [DEPTH-1:0]          hist;
  logic [DEPTH:0]            hist_ext;
  logic [NUM_TAPS*LAT_W-1:0] lat_q;
  logic [NUM_TAPS-1:0]       mode_q;
  logic [NUM_TAPS-1:0]       en_q;
  logic [NUM_TAPS-1:0]       exp_bit;
  logic [NUM_TAPS-1:0]       mis;
  logic                      any_mis;
  logic [CNT_W-1:0]          mis_cnt;
  logic [TAP_W-1:0]          mis_low;
  logic [SUM_W-1:0]          err_sum;
  logic [ERR_W-1:0]          err_next;
  logic [CYC_W-1:0]          cyc_next;

  // hist_ext[L] is head from L edges ago; index 0 is the live head for zero-latency taps
  assign hist_ext = {hist, head};

  always_comb begin
    exp_bit = '0;
    mis     = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      exp_bit[i] = hist_ext[lat_q[i*LAT_W +: LAT_W]];
      if (state == CHECK && en_q[i] &&
          CMP_W'(cycle_cnt) >= CMP_W'(lat_q[i*LAT_W +: LAT_W])) begin
        mis[i] = mode_q[i] ? (exp_bit[i] & ~tap[i]) : (exp_bit[i] ^ tap[i]);
      end
    end
  end

  always_comb begin
    mis_cnt = '0;
    mis_low = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      mis_cnt = mis_cnt + CNT_W'(mis[i]);
    end
    for (int i = NUM_TAPS - 1; i >= 0; i--) begin
      if (mis[i]) begin
        mis_low = TAP_W'(i);
      end
    end
  end

  assign any_mis  = |mis;
  assign err_sum  = SUM_W'(err_cnt) + SUM_W'(mis_cnt);
  assign err_next = (err_sum > SUM_W'({ERR_W{1'b1}})) ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
  assign cyc_next = (cycle_cnt == {CYC_W{1'b1}}) ? cycle_cnt : cycle_cnt + 1'b1;

  always_comb begin
    state_next = state;
    if (arm) begin
      state_next = CHECK;
    end else if (disarm && state != IDLE) begin
      state_next = IDLE;
    end else if (state == CHECK && stop_on_err && any_mis) begin
      state_next = HALT;
    end
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      hist <= '0;
    end else if (state == CHECK && !arm) begin
      hist <= hist_ext[DEPTH-1:0];
    end
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      lat_q           <= '0;
      mode_q          <= '0;
      en_q            <= '0;
      tap_err         <= '0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_tap   <= '0;
      first_err_cycle <= '0;
      cycle_cnt       <= '0;
    end else if (arm) begin
      lat_q           <= tap_lat;
      mode_q          <= tap_mode;
      en_q            <= tap_en;
      tap_err         <= '0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_tap   <= '0;
      first_err_cycle <= '0;
      cycle_cnt       <= '0;
    end else if (state == CHECK) begin
      tap_err <= tap_err | mis;
      err_cnt <= err_next;
      if (!first_err_valid && any_mis) begin
        first_err_valid <= 1'b1;
        first_err_tap   <= mis_low;
        first_err_cycle <= cycle_cnt;
      end
      // the halting cycle leaves cycle_cnt at the failing cycle's index
      if (state_next != HALT) begin
        cycle_cnt <= cyc_next;
      end
    end
  end

  assign checking = (state == CHECK);
  assign halted   = (state == HALT);

endmodule

// File: tb/tb_chain_path_monitor.sv
// tb/tb_chain_path_monitor.sv - randomized bench with a queue/array reference model of the chain monitor
`timescale 1ns/1ps
module tb_chain_path_monitor;
  localparam int NT   = 4;
  localparam int TW   = 2;
  localparam int LW_A = 14;
  localparam int EW_A = 16;
  localparam int CW_A = 32;
  localparam int LW_B = 4;
  localparam int EW_B = 4;
  localparam int CW_B = 6;
  localparam int HB   = 16384;

  logic prog_clk = 1'b0;
  logic pReset_n = 1'b0;
  logic arm = 1'b0, disarm = 1'b0, stop_on_err = 1'b0, head = 1'b0;
  logic [NT-1:0] tap = '0, tap_mode = '0, tap_en = '0;
  int lat_a [NT];
  logic [NT*LW_A-1:0] tap_lat_a;
  logic [NT*LW_B-1:0] tap_lat_b;

  logic checking_a, halted_a, fev_a;
  logic [NT-1:0] tap_err_a;
  logic [EW_A-1:0] err_cnt_a;
  logic [TW-1:0] fet_a;
  logic [CW_A-1:0] fec_a, cyc_a;
  logic checking_b, halted_b, fev_b;
  logic [NT-1:0] tap_err_b;
  logic [EW_B-1:0] err_cnt_b;
  logic [TW-1:0] fet_b;
  logic [CW_B-1:0] fec_b, cyc_b;

  always_comb begin
    tap_lat_a = '0;
    tap_lat_b = '0;
    for (int i = 0; i < NT; i++) begin
      tap_lat_a[i*LW_A +: LW_A] = LW_A'(lat_a[i]);
      tap_lat_b[i*LW_B +: LW_B] = LW_B'(lat_a[i]);
    end
  end

  chain_path_monitor #(.NUM_TAPS(NT), .LAT_W(LW_A), .ERR_W(EW_A), .CYC_W(CW_A)) dut_a (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .arm(arm), .disarm(disarm),
    .stop_on_err(stop_on_err), .head(head), .tap(tap), .tap_lat(tap_lat_a),
    .tap_mode(tap_mode), .tap_en(tap_en), .checking(checking_a), .halted(halted_a),
    .tap_err(tap_err_a), .err_cnt(err_cnt_a), .first_err_valid(fev_a),
    .first_err_tap(fet_a), .first_err_cycle(fec_a), .cycle_cnt(cyc_a));

  chain_path_monitor #(.NUM_TAPS(NT), .LAT_W(LW_B), .ERR_W(EW_B), .CYC_W(CW_B)) dut_b (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .arm(arm), .disarm(disarm),
    .stop_on_err(stop_on_err), .head(head), .tap(tap), .tap_lat(tap_lat_b),
    .tap_mode(tap_mode), .tap_en(tap_en), .checking(checking_b), .halted(halted_b),
    .tap_err(tap_err_b), .err_cnt(err_cnt_b), .first_err_valid(fev_b),
    .first_err_tap(fet_b), .first_err_cycle(fec_b), .cycle_cnt(cyc_b));

  always #5 prog_clk = ~prog_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic report();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  task automatic bail_if_flooded();
    if (n_bad >= 200) begin
      report();
      $finish;
    end
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
      bail_if_flooded();
    end
  endtask

  task automatic chk_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      bail_if_flooded();
    end
  endtask

  // Reference model: index 0 mirrors dut_a, index 1 mirrors dut_b; state 0=idle 1=check 2=halt
  int      m_st [2];
  longint  m_cyc [2], m_err [2], m_fec [2];
  bit      m_fev [2];
  int      m_fet [2];
  bit [NT-1:0] m_terr [2], m_mode [2], m_en [2];
  int      m_lat [2][NT];
  bit      hbuf [2][HB];
  int      hcount [2];
  longint  emax [2] = '{64'd65535, 64'd15};
  longint  cmax [2] = '{64'hFFFF_FFFF, 64'd63};
  int      lmod [2] = '{16384, 16};

  task automatic model_reset(input int x);
    m_st[x] = 0; m_cyc[x] = 0; m_err[x] = 0; m_fec[x] = 0; m_fev[x] = 1'b0;
    m_fet[x] = 0; m_terr[x] = '0; m_mode[x] = '0; m_en[x] = '0; hcount[x] = 0;
    for (int i = 0; i < NT; i++) m_lat[x][i] = 0;
  endtask

  task automatic bump(input int x);
    m_cyc[x] = (m_cyc[x] == cmax[x]) ? cmax[x] : m_cyc[x] + 1;
  endtask

  task automatic model_step(input int x);
    bit [NT-1:0] mis;
    bit e;
    int n;
    mis = '0;
    if (m_st[x] == 1) begin
      for (int i = 0; i < NT; i++) begin
        if (m_en[x][i] && m_cyc[x] >= longint'(m_lat[x][i])) begin
          e = (m_lat[x][i] == 0) ? head : hbuf[x][(hcount[x] - m_lat[x][i]) % HB];
          if (m_mode[x][i] ? (e && !tap[i]) : (e != tap[i])) mis[i] = 1'b1;
        end
      end
    end
    if (arm) begin
      model_reset(x);
      m_st[x] = 1;
      for (int i = 0; i < NT; i++) m_lat[x][i] = lat_a[i] % lmod[x];
      m_mode[x] = tap_mode;
      m_en[x] = tap_en;
    end else if (m_st[x] == 1) begin
      n = $countones(mis);
      m_terr[x] = m_terr[x] | mis;
      m_err[x] = (m_err[x] + n > emax[x]) ? emax[x] : m_err[x] + n;
      if (!m_fev[x] && mis != 0) begin
        m_fev[x] = 1'b1;
        m_fec[x] = m_cyc[x];
        for (int i = NT - 1; i >= 0; i--) if (mis[i]) m_fet[x] = i;
      end
      hbuf[x][hcount[x] % HB] = head;
      hcount[x]++;
      if (disarm) begin
        m_st[x] = 0;
        bump(x);
      end else if (stop_on_err && mis != 0) begin
        m_st[x] = 2;
      end else begin
        bump(x);
      end
    end else if (disarm) begin
      m_st[x] = 0;
    end
  endtask

  task automatic model_edge();
    if (!pReset_n) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0);
      model_step(1);
    end
  endtask

  task automatic model_async_reset();
    model_reset(0);
    model_reset(1);
  endtask

  always @(posedge prog_clk) model_edge();
  always @(negedge pReset_n) model_async_reset();

  task automatic compare_all();
    chk_vec("A_outputs",
      128'({checking_a, halted_a, tap_err_a, err_cnt_a, fev_a, fet_a, fec_a, cyc_a}),
      128'({m_st[0] == 1, m_st[0] == 2, m_terr[0], EW_A'(m_err[0]), m_fev[0],
            TW'(m_fet[0]), CW_A'(m_fec[0]), CW_A'(m_cyc[0])}));
    chk_vec("B_outputs",
      128'({checking_b, halted_b, tap_err_b, err_cnt_b, fev_b, fet_b, fec_b, cyc_b}),
      128'({m_st[1] == 1, m_st[1] == 2, m_terr[1], EW_B'(m_err[1]), m_fev[1],
            TW'(m_fet[1]), CW_B'(m_fec[1]), CW_B'(m_cyc[1])}));
  endtask

  always @(negedge prog_clk) compare_all();

  // Stimulus generator: drives taps from its own log of heads since the last arm
  int k;
  bit hlog[$];
  int g_lat [NT];
  bit [NT-1:0] g_mode;

  task automatic tick();
    @(posedge prog_clk);
    @(negedge prog_clk);
  endtask

  task automatic do_arm();
    arm = 1'b1;
    head = 1'($urandom);
    tap = NT'($urandom);
    tick();
    arm = 1'b0;
    for (int i = 0; i < NT; i++) g_lat[i] = lat_a[i];
    g_mode = tap_mode;
    hlog.delete();
    k = 0;
  endtask

  task automatic one_cycle(input int h, input bit [NT-1:0] bad);
    bit r, t;
    head = (h < 0) ? 1'($urandom) : 1'(h);
    hlog.push_back(head);
    for (int i = 0; i < NT; i++) begin
      if (k < g_lat[i]) begin
        t = 1'($urandom);
      end else begin
        r = hlog[k - g_lat[i]];
        if (g_mode[i]) t = r ? !bad[i] : 1'($urandom);
        else t = r ^ bad[i];
      end
      tap[i] = t;
    end
    tick();
    k++;
  endtask

  task automatic run(input int n, input int perr);
    bit [NT-1:0] bad;
    for (int c = 0; c < n; c++) begin
      bad = '0;
      for (int i = 0; i < NT; i++) if ($urandom_range(999) < perr) bad[i] = 1'b1;
      one_cycle(-1, bad);
    end
  endtask

  task automatic set_cfg(input int l0, input int l1, input int l2, input int l3,
                         input bit [NT-1:0] mode, input bit [NT-1:0] en);
    lat_a[0] = l0; lat_a[1] = l1; lat_a[2] = l2; lat_a[3] = l3;
    tap_mode = mode;
    tap_en = en;
  endtask

  initial begin
    int len;
    bit [NT-1:0] bad;

    repeat (3) tick();
    chk("reset_checking", longint'(checking_a), 0);
    chk("reset_err_cnt", longint'(err_cnt_a), 0);
    pReset_n = 1'b1;
    tick();

    // basic match, then a single tap0 error at cycle 10
    set_cfg(0, 3, 5, 2, 4'b0000, 4'b1111);
    do_arm();
    chk("arm_checking", longint'(checking_a), 1);
    chk("arm_cycle_cnt", longint'(cyc_a), 0);
    run(100, 0);
    chk("basic_err_cnt", longint'(err_cnt_a), 0);
    chk("basic_tap_err", longint'(tap_err_a), 0);
    chk("basic_cycle_cnt", longint'(cyc_a), 100);
    do_arm();
    run(10, 0);
    one_cycle(-1, 4'b0001);
    run(5, 0);
    chk("err10_tap_err", longint'(tap_err_a), 1);
    chk("err10_err_cnt", longint'(err_cnt_a), 1);
    chk("err10_first_tap", longint'(fet_a), 0);
    chk("err10_first_cycle", longint'(fec_a), 10);

    // long latency with warm-up garbage, then deepest history with an error right at the boundary
    set_cfg(0, 220, 0, 0, 4'b0000, 4'b0010);
    do_arm();
    run(2000, 0);
    chk("lat220_err_cnt", longint'(err_cnt_a), 0);
    set_cfg(0, 16383, 0, 0, 4'b0000, 4'b0010);
    do_arm();
    run(16383, 0);
    chk("lat16383_warmup_err", longint'(err_cnt_a), 0);
    one_cycle(-1, 4'b0010);
    run(100, 0);
    chk("lat16383_err_cnt", longint'(err_cnt_a), 1);
    chk("lat16383_first_cycle", longint'(fec_a), 16383);
    chk("cyc_saturate_b", longint'(cyc_b), 63);

    // implication mode
    set_cfg(0, 0, 1, 0, 4'b0100, 4'b0100);
    do_arm();
    for (int c = 0; c < 5; c++) one_cycle(0, 4'b0000);
    chk("impl_quiet", longint'(err_cnt_a), 0);
    one_cycle(1, 4'b0000);
    one_cycle(0, 4'b0100);
    run(5, 0);
    chk("impl_tap_err", longint'(tap_err_a), 4);
    chk("impl_first_cycle", longint'(fec_a), 6);

    // simultaneous errors on taps 1 and 3
    set_cfg(0, 2, 0, 4, 4'b0000, 4'b1010);
    do_arm();
    run(8, 0);
    one_cycle(-1, 4'b1010);
    run(3, 0);
    chk("simul_err_cnt", longint'(err_cnt_a), 2);
    chk("simul_first_tap", longint'(fet_a), 1);
    chk("simul_tap_err", longint'(tap_err_a), 10);

    // saturation of the narrow counter
    set_cfg(0, 0, 0, 0, 4'b0000, 4'b0001);
    do_arm();
    for (int c = 0; c < 20; c++) one_cycle(-1, 4'b0001);
    run(10, 0);
    chk("sat_err_cnt_a", longint'(err_cnt_a), 20);
    chk("sat_err_cnt_b", longint'(err_cnt_b), 15);

    // stop_on_err and rearm
    stop_on_err = 1'b1;
    do_arm();
    run(7, 0);
    one_cycle(-1, 4'b0001);
    chk("stop_halted", longint'(halted_a), 1);
    chk("stop_checking", longint'(checking_a), 0);
    chk("stop_cycle_cnt", longint'(cyc_a), 7);
    run(5, 1000);
    chk("halt_frozen_cycle", longint'(cyc_a), 7);
    chk("halt_frozen_err", longint'(err_cnt_a), 1);
    do_arm();
    chk("rearm_checking", longint'(checking_a), 1);
    chk("rearm_err_cnt", longint'(err_cnt_a), 0);
    chk("rearm_first_valid", longint'(fev_a), 0);
    chk("rearm_cycle_cnt", longint'(cyc_a), 0);
    stop_on_err = 1'b0;

    // disarm holds results
    run(5, 0);
    disarm = 1'b1;
    one_cycle(-1, 4'b0000);
    disarm = 1'b0;
    run(3, 0);
    chk("disarm_checking", longint'(checking_a), 0);

    // randomized runs with mid-run rearm/disarm and ignored config changes
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < NT; i++) lat_a[i] = ($urandom_range(3) == 0) ? 0 : int'($urandom_range(40));
      tap_mode = NT'($urandom);
      tap_en = NT'($urandom);
      stop_on_err = ($urandom_range(3) == 0);
      do_arm();
      for (int i = 0; i < NT; i++) lat_a[i] = int'($urandom_range(40));
      tap_mode = NT'($urandom);
      tap_en = NT'($urandom);
      len = int'($urandom_range(300, 50));
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(149) == 0) do_arm();
        disarm = ($urandom_range(99) == 0);
        bad = '0;
        for (int i = 0; i < NT; i++) if ($urandom_range(999) < 5) bad[i] = 1'b1;
        one_cycle(-1, bad);
        disarm = 1'b0;
      end
    end
    stop_on_err = 1'b0;

    // asynchronous reset in the middle of a run
    set_cfg(0, 0, 0, 0, 4'b0000, 4'b0001);
    do_arm();
    run(4, 0);
    for (int c = 0; c < 3; c++) one_cycle(-1, 4'b0001);
    run(2, 0);
    chk("pre_reset_err_cnt", longint'(err_cnt_a), 3);
    #1 pReset_n = 1'b0;
    #1;
    chk("rst_checking", longint'(checking_a), 0);
    chk("rst_err_cnt", longint'(err_cnt_a), 0);
    chk("rst_tap_err", longint'(tap_err_a), 0);
    chk("rst_first_valid", longint'(fev_a), 0);
    chk("rst_cycle_cnt", longint'(cyc_a), 0);
    chk("rst_first_cycle", longint'(fec_a), 0);
    #2 pReset_n = 1'b1;
    run(5, 0);
    chk("post_rst_idle", longint'(checking_a), 0);
    chk("post_rst_cycle", longint'(cyc_a), 0);
    do_arm();
    chk("post_rst_arm", longint'(checking_a), 1);
    run(3, 0);

    report();
    $finish;
  end

endmodule
